// File: rtl/dap_usb_tx_ring_packer_pkg.sv
// Shared types and helpers for the DAP USB IN ring packer.
// Read FSM state encoding and packet-start alignment round-up.
package dap_usb_tx_ring_packer_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACTIVE = 2'd1,
    RD_DONE   = 2'd2
  } rd_state_e;

  // Round a byte pointer up to a multiple of 2^lg2.
  // Already-aligned values are returned unchanged.
  function automatic logic [31:0] align_up(
    input logic [31:0] a,
    input int          lg2
  );
    logic [31:0] m;
    m = (32'd1 << lg2) - 32'd1;
    return (a + m) & ~m;
  endfunction

endpackage

// File: rtl/dap_usb_desc_fifo.sv
// Ring FIFO of {start address, length} packet descriptors.
// Ports: push/push_data, pop, head (oldest entry), count, full, empty.
module dap_usb_desc_fifo #(
  parameter int DW = 23,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/dap_usb_tx_ring_packer.sv
// USB IN packer: builds packets in a circular byte RAM, queues descriptors,
// streams the oldest packet to the USB core and retries unacknowledged ones.
// Ports:
//   write side : wr_addr/wr_data/wr_en, group_len/group_finish,
//                packet_finish, packet_abort, almost_full, ram_free, overflow
//   USB side   : usb_endpt, usb_txact, usb_txpop, usb_txpktfin,
//                usb_txcork, usb_txdata, usb_txlen
module dap_usb_tx_ring_packer
  import dap_usb_tx_ring_packer_pkg::*;
#(
  parameter int P_ENDPOINT = 1,
  parameter int RAM_AW     = 12,
  parameter int LEN_W      = 10,
  parameter int QUEUE_AW   = 3,
  parameter int ALIGN_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  group_len,
  input  logic              group_finish,
  input  logic              packet_finish,
  input  logic              packet_abort,
  output logic              almost_full,
  output logic [RAM_AW:0]   ram_free,
  output logic              overflow,
  input  logic [3:0]        usb_endpt,
  input  logic              usb_txact,
  input  logic              usb_txpop,
  input  logic              usb_txpktfin,
  output logic              usb_txcork,
  output logic [7:0]        usb_txdata,
  output logic [11:0]       usb_txlen
);

  localparam int PW     = RAM_AW + 1;
  localparam int DW     = PW + LEN_W;
  localparam int RAM_SZ = 1 << RAM_AW;
  localparam int DEPTH  = 1 << QUEUE_AW;

  logic [7:0]        ram [RAM_SZ];

  logic [PW-1:0]     grp_head;
  logic [PW-1:0]     pkt_start;
  logic [LEN_W-1:0]  pkt_len;
  logic [PW-1:0]     g_head_n;
  logic [LEN_W-1:0]  len_n;
  logic [PW-1:0]     aligned_n;
  logic [RAM_AW-1:0] wr_idx;

  logic [DW-1:0]     head_desc;
  logic [PW-1:0]     head_addr;
  logic [LEN_W-1:0]  head_len;
  logic [QUEUE_AW:0] count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [PW-1:0]     rd_base;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_addr_n;
  logic [RAM_AW-1:0] rd_idx;
  rd_state_e         state;
  logic              fin;
  logic              sel;

  // Group is folded in before the packet is committed.
  assign g_head_n  = group_finish ? grp_head + PW'(group_len) : grp_head;
  assign len_n     = group_finish ? pkt_len + group_len : pkt_len;
  assign aligned_n = PW'(align_up(32'(g_head_n), ALIGN_LOG2));
  assign wr_idx    = RAM_AW'(grp_head + PW'(wr_addr));

  assign push = packet_finish && !packet_abort && !full;
  assign pop  = (state == RD_DONE) && fin;

  assign {head_addr, head_len} = head_desc;

  dap_usb_desc_fifo #(
    .DW (DW),
    .AW (QUEUE_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pkt_start, len_n}),
    .pop       (pop),
    .head      (head_desc),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_head  <= '0;
      pkt_start <= '0;
      pkt_len   <= '0;
      overflow  <= 1'b0;
    end else if (packet_abort) begin
      grp_head <= pkt_start;
      pkt_len  <= '0;
    end else if (packet_finish) begin
      pkt_len <= '0;
      if (full) begin
        // Descriptor is lost, so its bytes are reclaimed.
        overflow <= 1'b1;
        grp_head <= pkt_start;
      end else begin
        pkt_start <= aligned_n;
        grp_head  <= aligned_n;
      end
    end else if (group_finish) begin
      grp_head <= g_head_n;
      pkt_len  <= len_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_idx] <= wr_data;
  end

  // Oldest byte still owned by the reader or the open packet.
  assign rd_base = empty ? pkt_start : head_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ram_free <= PW'(RAM_SZ);
    else       ram_free <= PW'(RAM_SZ) - (grp_head - rd_base);
  end

  assign almost_full = (count >= (QUEUE_AW+1)'(DEPTH - 1));
  assign sel         = (usb_endpt == 4'(P_ENDPOINT));
  assign usb_txcork  = !(sel && !empty);
  assign usb_txlen   = (sel && !empty) ? 12'(head_len) : 12'd0;

  always_comb begin
    rd_addr_n = rd_ptr;
    unique case (1'b1)
      (state == RD_IDLE):                rd_addr_n = head_addr;
      (state == RD_ACTIVE && usb_txpop): rd_addr_n = rd_ptr + PW'(1);
      default: ;
    endcase
  end

  assign rd_idx = RAM_AW'(rd_addr_n);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RD_IDLE;
      rd_ptr     <= '0;
      fin        <= 1'b0;
      usb_txdata <= 8'd0;
    end else begin
      // Prefetch keeps the next byte ready before it is popped.
      usb_txdata <= ram[rd_idx];
      unique case (state)
        RD_IDLE: begin
          rd_ptr <= head_addr;
          fin    <= 1'b0;
          if (sel && !empty && usb_txact) state <= RD_ACTIVE;
        end
        RD_ACTIVE: begin
          rd_ptr <= rd_addr_n;
          if (usb_txpktfin) fin   <= 1'b1;
          if (!usb_txact)   state <= RD_DONE;
        end
        RD_DONE: begin
          if (!fin) rd_ptr <= head_addr;
          fin   <= 1'b0;
          state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dap_usb_tx_ring_packer.sv
// Randomised bench for the USB IN ring packer.
// Model: byte array, descriptor queue and plain pointer arithmetic.
module tb_dap_usb_tx_ring_packer;

  localparam int RAM_SZ = 4096;
  localparam int PSZ    = 8192;
  localparam int DEPTH  = 8;
  localparam int ALIGN  = 16;

  logic        clk;
  logic        reset;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [9:0]  group_len;
  logic        group_finish;
  logic        packet_finish;
  logic        packet_abort;
  logic        almost_full;
  logic [12:0] ram_free;
  logic        overflow;
  logic [3:0]  usb_endpt;
  logic        usb_txact;
  logic        usb_txpop;
  logic        usb_txpktfin;
  logic        usb_txcork;
  logic [7:0]  usb_txdata;
  logic [11:0] usb_txlen;

  dap_usb_tx_ring_packer #(
    .P_ENDPOINT (1),
    .RAM_AW     (12),
    .LEN_W      (10),
    .QUEUE_AW   (3),
    .ALIGN_LOG2 (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .group_len     (group_len),
    .group_finish  (group_finish),
    .packet_finish (packet_finish),
    .packet_abort  (packet_abort),
    .almost_full   (almost_full),
    .ram_free      (ram_free),
    .overflow      (overflow),
    .usb_endpt     (usb_endpt),
    .usb_txact     (usb_txact),
    .usb_txpop     (usb_txpop),
    .usb_txpktfin  (usb_txpktfin),
    .usb_txcork    (usb_txcork),
    .usb_txdata    (usb_txdata),
    .usb_txlen     (usb_txlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  typedef struct {
    int addr;
    int len;
  } desc_t;

  desc_t      mq[$];
  logic [7:0] m_ram [RAM_SZ];
  int         m_grp;
  int         m_pstart;
  int         m_plen;
  logic [7:0] rx[$];
  logic [7:0] rx1[$];
  int         n_checks;
  int         n_fail;

  function automatic int m_align(input int a);
    return ((a + ALIGN - 1) / ALIGN * ALIGN) % PSZ;
  endfunction

  function automatic int m_free();
    int base;
    base = (mq.size() != 0) ? mq[0].addr : m_pstart;
    return RAM_SZ - ((m_grp - base + PSZ) % PSZ);
  endfunction

  task automatic m_finish();
    if (mq.size() == DEPTH) begin
      m_grp  = m_pstart;
      m_plen = 0;
    end else begin
      mq.push_back('{addr: m_pstart, len: m_plen});
      m_pstart = m_align(m_grp);
      m_grp    = m_pstart;
      m_plen   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input int d);
    wr_addr = 10'(off);
    wr_data = 8'(d);
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    m_ram[(m_grp + off) % RAM_SZ] = 8'(d);
  endtask

  task automatic do_group(input int len, input bit fill);
    if (fill)
      for (int i = 0; i < len; i++) wr(i, int'($urandom_range(0, 255)));
    group_len    = 10'(len);
    group_finish = 1'b1;
    tick();
    group_finish = 1'b0;
    m_grp  = (m_grp + len) % PSZ;
    m_plen = (m_plen + len) % 1024;
    tick();
  endtask

  task automatic do_finish();
    packet_finish = 1'b1;
    tick();
    packet_finish = 1'b0;
    m_finish();
    tick();
  endtask

  task automatic do_group_finish(input int len);
    for (int i = 0; i < len; i++) wr(i, int'($urandom_range(0, 255)));
    group_len     = 10'(len);
    group_finish  = 1'b1;
    packet_finish = 1'b1;
    tick();
    group_finish  = 1'b0;
    packet_finish = 1'b0;
    m_grp  = (m_grp + len) % PSZ;
    m_plen = (m_plen + len) % 1024;
    m_finish();
    tick();
  endtask

  task automatic do_abort(input bit all);
    packet_abort = 1'b1;
    if (all) begin
      group_len     = 10'd4;
      group_finish  = 1'b1;
      packet_finish = 1'b1;
    end
    tick();
    packet_abort  = 1'b0;
    group_finish  = 1'b0;
    packet_finish = 1'b0;
    m_grp  = m_pstart;
    m_plen = 0;
    tick();
  endtask

  // USB core side: one transfer with npop byte pops.
  task automatic xfer(input int npop, input bit fin);
    rx.delete();
    usb_txact = 1'b1;
    tick();
    for (int i = 0; i < npop; i++) begin
      rx.push_back(usb_txdata);
      usb_txpop = 1'b1;
      tick();
    end
    usb_txpop = 1'b0;
    if (fin) begin
      usb_txpktfin = 1'b1;
      tick();
      usb_txpktfin = 1'b0;
    end
    usb_txact = 1'b0;
    tick();
    tick();
    if (fin) void'(mq.pop_front());
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (usb_txcork !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_cork got=%b exp=1", usb_txcork);
    end
    n_checks++;
    if (usb_txlen !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_txlen got=%0d exp=0", usb_txlen);
    end
    n_checks++;
    if (ram_free !== 13'd4096) begin
      n_fail++;
      $display("FAIL rst_free got=%0d exp=4096", ram_free);
    end
    n_checks++;
    if (almost_full !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got=%b%b exp=00", almost_full, overflow);
    end
    n_checks++;
    if (usb_txdata !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_txdata got=%0h exp=0", usb_txdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int a;
    int len;
    do_group(5, 1);
    do_group(7, 1);
    n_checks++;
    if (ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL basic_free_open got=%0d exp=%0d", ram_free, m_free());
    end
    do_finish();
    a   = mq[0].addr;
    len = mq[0].len;
    n_checks++;
    if (usb_txlen !== 12'd12 || usb_txcork !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_head got=%0d/%b exp=12/0", usb_txlen, usb_txcork);
    end
    xfer(len, 1);
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
        n_fail++;
        $display("FAIL basic_byte%0d got=%0h exp=%0h", i, rx[i], m_ram[(a + i) % RAM_SZ]);
      end
    end
    n_checks++;
    if (ram_free !== 13'd4096 || usb_txcork !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after got=%0d/%b exp=4096/1", ram_free, usb_txcork);
    end
  endtask

  task automatic test_retry();
    int a;
    do_group(12, 1);
    do_finish();
    a = mq[0].addr;
    xfer(12, 0);
    rx1 = rx;
    n_checks++;
    if (usb_txcork !== 1'b0 || usb_txlen !== 12'd12) begin
      n_fail++;
      $display("FAIL retry_kept got=%b/%0d exp=0/12", usb_txcork, usb_txlen);
    end
    xfer(12, 1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (rx1[i] !== m_ram[(a + i) % RAM_SZ] || rx[i] !== rx1[i]) begin
        n_fail++;
        $display("FAIL retry_byte%0d got=%0h/%0h exp=%0h", i, rx1[i], rx[i], m_ram[(a + i) % RAM_SZ]);
      end
    end
    n_checks++;
    if (usb_txcork !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_popped got=%b exp=1", usb_txcork);
    end
  endtask

  task automatic test_wrap();
    int a;
    int need;
    while (m_grp < 4080) begin
      need = 4080 - m_grp;
      do_group(need > 1023 ? 1000 : need, 0);
      do_finish();
      xfer(0, 1);
    end
    do_group(10, 1);
    n_checks++;
    if (ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL wrap_free10 got=%0d exp=%0d", ram_free, m_free());
    end
    do_group(20, 1);
    n_checks++;
    if (ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL wrap_free30 got=%0d exp=%0d", ram_free, m_free());
    end
    do_finish();
    a = mq[0].addr;
    n_checks++;
    if (usb_txlen !== 12'd30 || ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL wrap_head got=%0d/%0d exp=30/%0d", usb_txlen, ram_free, m_free());
    end
    xfer(30, 1);
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
        n_fail++;
        $display("FAIL wrap_byte%0d got=%0h exp=%0h", i, rx[i], m_ram[(a + i) % RAM_SZ]);
      end
    end
    n_checks++;
    if (ram_free !== 13'd4096) begin
      n_fail++;
      $display("FAIL wrap_after got=%0d exp=4096", ram_free);
    end
  endtask

  task automatic test_overflow();
    int a;
    int len;
    for (int k = 0; k < DEPTH; k++) begin
      do_group(int'($urandom_range(1, 4)), 1);
      do_finish();
      n_checks++;
      if (almost_full !== (mq.size() >= DEPTH - 1)) begin
        n_fail++;
        $display("FAIL ovf_af%0d got=%b exp=%b", k, almost_full, mq.size() >= DEPTH - 1);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early got=%b exp=0", overflow);
    end
    do_group(5, 1);
    do_finish();
    n_checks++;
    if (overflow !== 1'b1 || ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL ovf_set got=%b/%0d exp=1/%0d", overflow, ram_free, m_free());
    end
    while (mq.size() != 0) begin
      a   = mq[0].addr;
      len = mq[0].len;
      n_checks++;
      if (usb_txlen !== 12'(len)) begin
        n_fail++;
        $display("FAIL ovf_len got=%0d exp=%0d", usb_txlen, len);
      end
      xfer(len, 1);
      for (int i = 0; i < len; i++) begin
        n_checks++;
        if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
          n_fail++;
          $display("FAIL ovf_byte got=%0h exp=%0h", rx[i], m_ram[(a + i) % RAM_SZ]);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky got=%b/%b exp=1/0", overflow, almost_full);
    end
  endtask

  task automatic test_abort();
    int a;
    do_group(9, 1);
    do_abort(0);
    do_group(3, 1);
    do_finish();
    a = mq[0].addr;
    n_checks++;
    if (usb_txlen !== 12'd3) begin
      n_fail++;
      $display("FAIL abort_len got=%0d exp=3", usb_txlen);
    end
    xfer(3, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
        n_fail++;
        $display("FAIL abort_byte%0d got=%0h exp=%0h", i, rx[i], m_ram[(a + i) % RAM_SZ]);
      end
    end
    do_group(5, 1);
    do_abort(1);
    n_checks++;
    if (usb_txcork !== 1'b1 || ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL abort_wins got=%b/%0d exp=1/%0d", usb_txcork, ram_free, m_free());
    end
  endtask

  task automatic test_zlp();
    do_finish();
    n_checks++;
    if (usb_txlen !== 12'd0 || usb_txcork !== 1'b0) begin
      n_fail++;
      $display("FAIL zlp_head got=%0d/%b exp=0/0", usb_txlen, usb_txcork);
    end
    xfer(0, 1);
    n_checks++;
    if (usb_txcork !== 1'b1 || ram_free !== 13'(m_free())) begin
      n_fail++;
      $display("FAIL zlp_pop got=%b/%0d exp=1/%0d", usb_txcork, ram_free, m_free());
    end
  endtask

  task automatic test_endpoint();
    int a;
    do_group(3, 1);
    do_group_finish(6);
    a = mq[0].addr;
    usb_endpt = 4'd2;
    tick();
    n_checks++;
    if (usb_txcork !== 1'b1 || usb_txlen !== 12'd0) begin
      n_fail++;
      $display("FAIL ep_other got=%b/%0d exp=1/0", usb_txcork, usb_txlen);
    end
    usb_endpt = 4'd1;
    tick();
    n_checks++;
    if (usb_txcork !== 1'b0 || usb_txlen !== 12'd9) begin
      n_fail++;
      $display("FAIL ep_same_cycle got=%b/%0d exp=0/9", usb_txcork, usb_txlen);
    end
    xfer(9, 1);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
        n_fail++;
        $display("FAIL ep_byte%0d got=%0h exp=%0h", i, rx[i], m_ram[(a + i) % RAM_SZ]);
      end
    end
  endtask

  task automatic test_random();
    int a;
    int len;
    int ng;
    for (int it = 0; it < 24; it++) begin
      ng = int'($urandom_range(0, 3));
      for (int g = 0; g < ng; g++) do_group(int'($urandom_range(0, 40)), 1);
      if ($urandom_range(0, 5) == 0) begin
        do_abort(0);
        do_group(int'($urandom_range(1, 20)), 1);
      end
      if ($urandom_range(0, 1) == 0) do_finish();
      else do_group_finish(int'($urandom_range(0, 30)));
      a   = mq[0].addr;
      len = mq[0].len;
      n_checks++;
      if (usb_txlen !== 12'(len) || ram_free !== 13'(m_free())) begin
        n_fail++;
        $display("FAIL rnd%0d_head got=%0d/%0d exp=%0d/%0d", it, usb_txlen, ram_free, len, m_free());
      end
      if ($urandom_range(0, 2) == 0) xfer(int'($urandom_range(0, len)), 0);
      xfer(len, 1);
      for (int i = 0; i < len; i++) begin
        n_checks++;
        if (rx[i] !== m_ram[(a + i) % RAM_SZ]) begin
          n_fail++;
          $display("FAIL rnd%0d_byte%0d got=%0h exp=%0h", it, i, rx[i], m_ram[(a + i) % RAM_SZ]);
        end
      end
      n_checks++;
      if (usb_txcork !== 1'b1 || ram_free !== 13'(m_free())) begin
        n_fail++;
        $display("FAIL rnd%0d_after got=%b/%0d exp=1/%0d", it, usb_txcork, ram_free, m_free());
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_grp         = 0;
    m_pstart      = 0;
    m_plen        = 0;
    reset         = 1'b1;
    wr_addr       = '0;
    wr_data       = '0;
    wr_en         = 1'b0;
    group_len     = '0;
    group_finish  = 1'b0;
    packet_finish = 1'b0;
    packet_abort  = 1'b0;
    usb_endpt     = 4'd1;
    usb_txact     = 1'b0;
    usb_txpop     = 1'b0;
    usb_txpktfin  = 1'b0;
    test_reset();
    test_basic();
    test_retry();
    test_wrap();
    test_overflow();
    test_abort();
    test_zlp();
    test_endpoint();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
